cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//  Round-robin arbiter that shares the single Common Data Bus (CDB) among the
//  Tomasulo functional units (ALU, CMP/branch, load/store). Each cycle it picks
//  at most one completed result (ROB tag + value) and drives it, registered, to
//  the CDB. Reservation stations, the ROB and the regfile snoop the CDB.
//  It sits between the functional-unit outputs and the CDB broadcast net.
// PARAMETERS
//  N_REQ   3   number of requesting functional units; 0=ALU, 1=CMP, 2=LSU
//  TAG_W   3   ROB tag width; matches rvfi_word.rd_tag
//  DATA_W  32  result width (rv32i_word)
// PORTS
//  clk        in   1             clock; all state updates on the rising edge
//  rst_n      in   1             asynchronous active-low reset
//  flush      in   1             mispredict flush; kills arbitration and CDB output
//  req_valid  in   N_REQ         requester i holds a completed result
//  req_tag    in   N_REQ*TAG_W   ROB tag of requester i, at bits [i*TAG_W +: TAG_W]
//  req_data   in   N_REQ*DATA_W  result value of requester i, at bits [i*DATA_W +: DATA_W]
//  req_ready  out  N_REQ         one-hot grant; requester i's result is taken this cycle
//  cdb_valid  out  1             CDB carries a valid broadcast this cycle
//  cdb_tag    out  TAG_W         broadcast ROB tag
//  cdb_data   out  DATA_W        broadcast value
//  cdb_src    out  $clog2(N_REQ) index of the requester that produced the broadcast
// BEHAVIOUR
//  Reset (rst_n=0, asynchronous):
//   - cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0, rr_ptr=0.
//   - req_ready is all zeros while rst_n=0.
//  Arbitration (combinational, same cycle):
//   - Scan rr_ptr, rr_ptr+1, ... modulo N_REQ.
//   - The first i with req_valid[i]=1 wins; req_ready is one-hot at that i.
//   - req_ready is all zeros if no requester is valid or flush=1.
//   - req_ready never asserts for a requester with req_valid=0.
//  Handshake:
//   - A transfer occurs when req_valid[i] && req_ready[i].
//   - req_valid must not depend on req_ready.
//   - Once asserted, req_valid/tag/data hold stable until the transfer.
//   - A requester may assert a new result in the cycle after its transfer.
//  Output register, latency 1 (transfer in cycle t appears in cycle t+1):
//   - Transfer in cycle t: in t+1, cdb_valid=1 and cdb_tag/data/src = winner's values.
//   - No transfer in cycle t: in t+1, cdb_valid=0; cdb_tag/data/src keep their old values.
//   - The CDB always accepts, so there is no back-pressure from consumers.
//  Pointer:
//   - On a transfer by requester w: rr_ptr <= (w==N_REQ-1) ? 0 : w+1 (wrap-around).
//   - With no transfer, rr_ptr is unchanged.
//  Fairness:
//   - A continuously valid requester is granted within N_REQ cycles.
//   - Only one transfer per cycle; back-to-back grants are allowed (full throughput).
//  Flush (synchronous, cycle t):
//   - No grant in cycle t.
//   - In t+1: cdb_valid=0 (any broadcast registered in t-1 still shows in t), rr_ptr=0.
//   - Requesters drop their own valids; the arbiter holds no other state.
//  Simultaneous flush and reset: reset wins.
//  Reset asserted mid-broadcast: cdb_valid drops immediately (async).
// TESTING
//  1. Reset, then req_valid=3'b000 for 5 cycles
//     -> req_ready=0 and cdb_valid=0 throughout.
//  2. Single request: req_valid=3'b010, tag=5, data=32'hDEADBEEF
//     -> req_ready=3'b010 the same cycle;
//     -> next cycle cdb_valid=1, cdb_tag=5, cdb_data=32'hDEADBEEF, cdb_src=1; rr_ptr=2.
//  3. req_valid=3'b111 held for 6 cycles from rr_ptr=0
//     -> grants 0,1,2,0,1,2 in order;
//     -> cdb_valid=1 on every cycle from the second onward.
//  4. Wrap: rr_ptr=2, req_valid=3'b101 -> grant 2, then 0.
//  5. Flush while req_valid=3'b011 with a broadcast pending
//     -> req_ready=0; next cycle cdb_valid=0 and rr_ptr=0;
//     -> after flush deasserts, requester 0 is granted first.
//  6. Deassert rst_n while cdb_valid=1
//     -> cdb_valid=0 immediately (async);
//     -> after release, outputs and rr_ptr are 0.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the single Common Data Bus among the functional units.
// One completed result per cycle is granted combinationally and broadcast from a register one cycle later.
module cdb_arbiter #(
    parameter  int N_REQ  = 3,
    parameter  int TAG_W  = 3,
    parameter  int DATA_W = 32,
    localparam int SRC_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*TAG_W-1:0]    req_tag,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      cdb_valid,
    output logic [TAG_W-1:0]          cdb_tag,
    output logic [DATA_W-1:0]         cdb_data,
    output logic [SRC_W-1:0]          cdb_src
);

    logic [SRC_W-1:0] rr_ptr;
    logic [SRC_W-1:0] win_idx;
    logic [SRC_W:0]   scan_idx;
    logic             found;
    logic             transfer;

    // NOTE: every variable written here gets a default first, so no path
    // through the loop can leave one unassigned and infer a latch.
    always_comb begin
        req_ready = '0;
        win_idx   = '0;
        scan_idx  = '0;
        found     = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            // scan_idx is one bit wider than rr_ptr so rr_ptr + k cannot overflow before the modulo.
            scan_idx = {1'b0, rr_ptr} + (SRC_W+1)'(k);
            if (scan_idx >= (SRC_W+1)'(N_REQ)) begin
                scan_idx = scan_idx - (SRC_W+1)'(N_REQ);
            end
            if (!found && req_valid[scan_idx[SRC_W-1:0]]) begin
                found   = 1'b1;
                win_idx = scan_idx[SRC_W-1:0];
            end
        end
        // A flush kills the grant. Holding reset does too, so no requester sees its result taken.
        if (found && rst_n && !flush) begin
            req_ready[win_idx] = 1'b1;
        end
    end

    assign transfer = |req_ready;

    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order; reset is asynchronous so
    // the broadcast drops the instant rst_n falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
            cdb_src   <= '0;
            rr_ptr    <= '0;
        end else begin
            cdb_valid <= transfer;
            if (transfer) begin
                cdb_tag  <= req_tag[win_idx*TAG_W +: TAG_W];
                cdb_data <= req_data[win_idx*DATA_W +: DATA_W];
                cdb_src  <= win_idx;
            end
            if (flush) begin
                rr_ptr <= '0;
            end else if (transfer) begin
                rr_ptr <= (win_idx == SRC_W'(N_REQ-1)) ? '0 : win_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: a table of vectors with expected grants, plus a scoreboard queue of CDB results.
// Hand-written sequences cover reset during a broadcast.
module tb_cdb_arbiter;

    localparam int N_REQ  = 3;
    localparam int TAG_W  = 3;
    localparam int DATA_W = 32;
    localparam int SRC_W  = 2;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    flush;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*TAG_W-1:0]  req_tag;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic                    cdb_valid;
    logic [TAG_W-1:0]        cdb_tag;
    logic [DATA_W-1:0]       cdb_data;
    logic [SRC_W-1:0]        cdb_src;

    cdb_arbiter #(.N_REQ(N_REQ), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .req_valid (req_valid),
        .req_tag   (req_tag),
        .req_data  (req_data),
        .req_ready (req_ready),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .cdb_src   (cdb_src)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N_REQ-1:0]        valid;
        logic                    flush;
        logic [N_REQ*TAG_W-1:0]  tag;
        logic [N_REQ*DATA_W-1:0] data;
        logic [N_REQ-1:0]        ready;
    } vec_t;

    typedef struct {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
        logic [SRC_W-1:0]  src;
    } cdb_t;

    vec_t tbl[$];
    cdb_t sb[$];
    cdb_t last_cdb;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [N_REQ-1:0] v, input logic f, input logic [N_REQ-1:0] r);
        vec_t e;
        int   n;
        n = tbl.size();
        e.valid = v;
        e.flush = f;
        e.ready = r;
        for (int i = 0; i < N_REQ; i++) begin
            e.tag[i*TAG_W +: TAG_W]    = TAG_W'((n * 3 + i) % 8);
            e.data[i*DATA_W +: DATA_W] = 32'hC0DE_0000 + 32'(n * 16 + i);
        end
        tbl.push_back(e);
    endtask

    // Drive one vector, check the grant, push the expected broadcast and compare it one cycle later.
    task automatic step(input vec_t v, input int n);
        cdb_t exp_c;
        cdb_t got_c;
        req_valid = v.valid;
        flush     = v.flush;
        req_tag   = v.tag;
        req_data  = v.data;
        #1;
        check($sformatf("ready[%0d]", n), 64'(req_ready), 64'(v.ready));
        exp_c       = last_cdb;
        exp_c.valid = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (v.ready[i]) begin
                exp_c.valid = 1'b1;
                exp_c.tag   = v.tag[i*TAG_W +: TAG_W];
                exp_c.data  = v.data[i*DATA_W +: DATA_W];
                exp_c.src   = SRC_W'(i);
            end
        end
        last_cdb = exp_c;
        sb.push_back(exp_c);
        @(posedge clk);
        #1;
        got_c = sb.pop_front();
        check($sformatf("cdb_valid[%0d]", n), 64'(cdb_valid), 64'(got_c.valid));
        check($sformatf("cdb_tag[%0d]", n),   64'(cdb_tag),   64'(got_c.tag));
        check($sformatf("cdb_data[%0d]", n),  64'(cdb_data),  64'(got_c.data));
        check($sformatf("cdb_src[%0d]", n),   64'(cdb_src),   64'(got_c.src));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        req_valid = 3'b111;
        req_tag   = '0;
        req_data  = '0;
        last_cdb  = '{default: '0};

        // Idle after reset, then a single request from CMP.
        for (int i = 0; i < 5; i++) add(3'b000, 1'b0, 3'b000);
        add(3'b010, 1'b0, 3'b010);
        tbl[5].tag[1*TAG_W +: TAG_W]    = 3'd5;
        tbl[5].data[1*DATA_W +: DATA_W] = 32'hDEAD_BEEF;
        // An idle cycle leaves tag/data/src unchanged. Then a wrap from rr_ptr=2 and a realign to rr_ptr=0.
        add(3'b000, 1'b0, 3'b000);
        add(3'b101, 1'b0, 3'b100);
        add(3'b101, 1'b0, 3'b001);
        add(3'b100, 1'b0, 3'b100);
        // All requesters valid: rotating grants.
        for (int i = 0; i < 2; i++) begin
            add(3'b111, 1'b0, 3'b001);
            add(3'b111, 1'b0, 3'b010);
            add(3'b111, 1'b0, 3'b100);
        end
        // A flush with a broadcast pending resets rr_ptr, so requester 0 wins afterwards.
        add(3'b011, 1'b0, 3'b001);
        add(3'b011, 1'b1, 3'b000);
        add(3'b011, 1'b0, 3'b001);
        add(3'b010, 1'b0, 3'b010);

        #1;
        check("reset_ready", 64'(req_ready), 64'(3'b000));
        check("reset_cdb_valid", 64'(cdb_valid), 64'(1'b0));
        check("reset_cdb_fields", {29'(cdb_tag), cdb_data, cdb_src}, 64'd0);
        req_valid = 3'b000;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int n = 0; n < tbl.size(); n++) step(tbl[n], n);

        // Reset asserted while the last vector's broadcast is still on the CDB.
        check("pre_reset_cdb_valid", 64'(cdb_valid), 64'(1'b1));
        req_valid = 3'b111;
        rst_n     = 1'b0;
        #1;
        check("async_cdb_valid", 64'(cdb_valid), 64'(1'b0));
        check("async_cdb_fields", {29'(cdb_tag), cdb_data, cdb_src}, 64'd0);
        check("async_ready", 64'(req_ready), 64'(3'b000));
        req_valid = 3'b000;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        last_cdb = '{default: '0};
        check("post_reset_cdb_valid", 64'(cdb_valid), 64'(1'b0));
        tbl.delete();
        add(3'b111, 1'b0, 3'b001);
        add(3'b111, 1'b0, 3'b010);
        for (int n = 0; n < tbl.size(); n++) step(tbl[n], 100 + n);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
